memory_port_arbiter: RTL

//   Shares one single-port word memory (comb read, sync write) between the fetch

---
 rtl/memory_port_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter that shares one single-port word memory (combinational
// read, synchronous write) between a read-only fetch port and a read/write
// data port. One access is in flight at a time. Optional wait states sit
// between grant and memory access. Byte-masked writes are done as a
// read-modify-write.
//
// Handshake: a requester holds req and its fields until it sees gnt high.
// gnt is combinational and only appears in IDLE. The grant cycle is the
// transfer; request inputs are ignored after that. Completion is a one-cycle
// rvalid pulse on the owner's port. busy_o exposes the FSM (high whenever the
// state is not IDLE).
module memory_port_arbiter #(
   parameter int ADDRES_BIT  = 32,
   parameter int DATA_BIT    = 32,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  fetch_req_i,
   input  logic [ADDRES_BIT-1:0] fetch_addr_i,
   output logic                  fetch_gnt_o,
   output logic                  fetch_rvalid_o,
   output logic [DATA_BIT-1:0]   fetch_rdata_o,
   input  logic                  data_req_i,
   input  logic                  data_we_i,
   input  logic [ADDRES_BIT-1:0] data_addr_i,
   input  logic [DATA_BIT-1:0]   data_wdata_i,
   input  logic [DATA_BIT/8-1:0] data_be_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   output logic [DATA_BIT-1:0]   data_rdata_o,
   output logic                  busy_o,
   output logic [ADDRES_BIT-1:0] mem_addr_o,
   output logic [DATA_BIT-1:0]   mem_wdata_o,
   output logic                  mem_we_o,
   input  logic [DATA_BIT-1:0]   mem_rdata_i
);
   localparam int BE_BIT = DATA_BIT / 8;
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
   localparam logic [ADDRES_BIT-1:0] WORD_MASK = ~ADDRES_BIT'(3);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_RMW_WR, S_RESP} state_t;

   state_t                state_q, state_d;
   logic                  owner_data_q, owner_data_d;  // 1: access in flight belongs to data port
   logic                  last_data_q, last_data_d;    // 1: data port won the previous grant
   logic [ADDRES_BIT-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [DATA_BIT-1:0]   wdata_q, wdata_d;
   logic [BE_BIT-1:0]     be_q, be_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DATA_BIT-1:0]   rmw_q, rmw_d;
   logic [DATA_BIT-1:0]   fetch_rdata_q, fetch_rdata_d;
   logic [DATA_BIT-1:0]   data_rdata_q, data_rdata_d;
   logic [ADDRES_BIT-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_BIT-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_BIT-1:0]   merged;
   logic                  gnt_fetch, gnt_data, mem_we, fetch_rvalid, data_rvalid;

   // Byte merge for the write half of a read-modify-write.
   always_comb begin
      merged = rmw_q;
      for (int i = 0; i < BE_BIT; i++) begin
         merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : rmw_q[8*i +: 8];
      end
   end

   // Next-state, arbitration and memory-side outputs.
   always_comb begin
      state_d       = state_q;
      owner_data_d  = owner_data_q;
      last_data_d   = last_data_q;
      addr_d        = addr_q;
      we_d          = we_q;
      wdata_d       = wdata_q;
      be_d          = be_q;
      cnt_d         = cnt_q;
      rmw_d         = rmw_q;
      fetch_rdata_d = fetch_rdata_q;
      data_rdata_d  = data_rdata_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      gnt_fetch     = 1'b0;
      gnt_data      = 1'b0;
      mem_we        = 1'b0;
      fetch_rvalid  = 1'b0;
      data_rvalid   = 1'b0;
      case (state_q)
         S_IDLE: begin
            gnt_fetch = fetch_req_i && (!data_req_i || last_data_q);
            gnt_data  = data_req_i && (!fetch_req_i || !last_data_q);
            if (gnt_fetch || gnt_data) begin
               owner_data_d = gnt_data;
               last_data_d  = gnt_data;
               addr_d       = gnt_data ? data_addr_i : fetch_addr_i;
               we_d         = gnt_data && data_we_i;
               wdata_d      = gnt_data ? data_wdata_i : '0;
               be_d         = gnt_data ? data_be_i : '0;
               cnt_d        = WAIT_LOAD;
               state_d      = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_ACCESS;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_ACCESS: begin
            mem_addr_d = addr_q & WORD_MASK;
            if (!we_q) begin
               if (owner_data_q) data_rdata_d  = mem_rdata_i;
               else              fetch_rdata_d = mem_rdata_i;
               state_d = S_RESP;
            end else if (&be_q) begin
               mem_we       = 1'b1;
               mem_wdata_d  = wdata_q;
               data_rdata_d = '0;
               state_d      = S_RESP;
            end else if (be_q == '0) begin
               data_rdata_d = '0;
               state_d      = S_RESP;
            end else begin
               rmw_d   = mem_rdata_i;
               state_d = S_RMW_WR;
            end
         end
         S_RMW_WR: begin
            mem_addr_d   = addr_q & WORD_MASK;
            mem_we       = 1'b1;
            mem_wdata_d  = merged;
            data_rdata_d = '0;
            state_d      = S_RESP;
         end
         S_RESP: begin
            if (owner_data_q) data_rvalid  = 1'b1;
            else              fetch_rvalid = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and latched-request registers; reset returns to IDLE favouring fetch.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         owner_data_q  <= 1'b0;
         last_data_q   <= 1'b1;
         addr_q        <= '0;
         we_q          <= 1'b0;
         wdata_q       <= '0;
         be_q          <= '0;
         cnt_q         <= '0;
         rmw_q         <= '0;
         fetch_rdata_q <= '0;
         data_rdata_q  <= '0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         owner_data_q  <= owner_data_d;
         last_data_q   <= last_data_d;
         addr_q        <= addr_d;
         we_q          <= we_d;
         wdata_q       <= wdata_d;
         be_q          <= be_d;
         cnt_q         <= cnt_d;
         rmw_q         <= rmw_d;
         fetch_rdata_q <= fetch_rdata_d;
         data_rdata_q  <= data_rdata_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
      end
   end

   // Reset suppresses grants, write strobes and responses in the same cycle.
   assign fetch_gnt_o    = gnt_fetch && !rst_i;
   assign data_gnt_o     = gnt_data && !rst_i;
   assign fetch_rvalid_o = fetch_rvalid && !rst_i;
   assign data_rvalid_o  = data_rvalid && !rst_i;
   assign mem_we_o       = mem_we && !rst_i;
   assign fetch_rdata_o  = fetch_rdata_q;
   assign data_rdata_o   = data_rdata_q;
   assign busy_o         = (state_q != S_IDLE);
   assign mem_addr_o     = mem_addr_d;
   assign mem_wdata_o    = mem_wdata_d;

endmodule
